// File: rtl/test_monitor_pkg.sv
// Shared types and default constants for the test monitor.
package test_monitor_pkg;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_RESET_CYCLES = 4;
   localparam int DEF_TIMEOUT      = 1000;
   localparam int DEF_CNT_W        = 32;

endpackage

// File: rtl/test_monitor_watchdog.sv
// Loadable up-counter with clear and enable.
// tc flags the last count before the budget runs out (count == TIMEOUT-1).
module test_monitor_watchdog
   import test_monitor_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             tc
);

   // Counter: clear beats load, and load beats enable.
   always_ff @(posedge clock) begin
      if (!reset || clear)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (enable)
         count <= count + 1'b1;
   end

   assign tc = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/test_monitor.sv
// Test monitor: holds the bench in reset, then watches fail/finish under a
// cycle budget and latches a single sticky verdict and the run length.
// Optional macro TEST_MONITOR_FAIL_FAST_EN: a fail during RUN ends the run
// immediately with a fail verdict.
module test_monitor
   import test_monitor_pkg::*;
#(
   parameter int RESET_CYCLES = DEF_RESET_CYCLES,
   parameter int TIMEOUT      = DEF_TIMEOUT,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             test_fail,
   input  logic             test_finish,
   output logic             test_reset,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [CNT_W-1:0] cycles
);

   localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   state_t        state;
   logic [HW-1:0] hold_cnt;
   logic          fail_seen;
   logic          wd_tc;

   // The run-length counter stays at zero in HOLD, counts every RUN cycle,
   // and freezes in DONE.
   test_monitor_watchdog #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clock    (clock),
      .reset    (reset),
      .clear    (state == HOLD),
      .load     (1'b0),
      .load_val ('0),
      .enable   (state == RUN),
      .count    (cycles),
      .tc       (wd_tc)
   );

   // Sequencer and verdict registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= HOLD;
         hold_cnt   <= '0;
         fail_seen  <= 1'b0;
         test_reset <= 1'b1;
         done       <= 1'b0;
         pass       <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         case (state)
            HOLD: begin
               hold_cnt <= hold_cnt + 1'b1;
               if (hold_cnt == HW'(RESET_CYCLES - 1)) begin
                  state      <= RUN;
                  test_reset <= 1'b0;
               end
            end
            RUN: begin
               fail_seen <= fail_seen | test_fail;
`ifdef TEST_MONITOR_FAIL_FAST_EN
               if (test_fail) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  pass    <= 1'b0;
                  timeout <= 1'b0;
               end else
`endif
               if (test_finish) begin
                  // A fail in the finishing cycle still counts against pass.
                  state   <= DONE;
                  done    <= 1'b1;
                  pass    <= !(fail_seen | test_fail);
                  timeout <= 1'b0;
               end else if (wd_tc) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  pass    <= 1'b0;
                  timeout <= 1'b1;
               end
            end
            DONE: begin
               // Verdict is sticky; only reset leaves DONE.
            end
            default: state <= HOLD;
         endcase
      end
   end

endmodule

// File: tb/tb_test_monitor.sv
// Self-checking bench for test_monitor: directed scenarios plus randomized
// fail/finish schedules compared with a schedule-level verdict model.
module tb_test_monitor;

   localparam int RC = 4;
   localparam int TO = 10;
   localparam int CW = 16;
   localparam int SL = TO + 4;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          test_fail = 1'b0;
   logic          test_finish = 1'b0;
   logic          test_reset, done, pass, timeout;
   logic [CW-1:0] cycles;

   int checks = 0;
   int failures = 0;

   // Per RUN cycle (1-based) input schedule.
   bit s_fail [1:SL];
   bit s_fin  [1:SL];

   always #5 clock = ~clock;

   test_monitor #(
      .RESET_CYCLES (RC),
      .TIMEOUT      (TO),
      .CNT_W        (CW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .test_fail   (test_fail),
      .test_finish (test_finish),
      .test_reset  (test_reset),
      .done        (done),
      .pass        (pass),
      .timeout     (timeout),
      .cycles      (cycles)
   );

   task automatic clear_sched();
      for (int i = 1; i <= SL; i++) begin
         s_fail[i] = 1'b0;
         s_fin[i]  = 1'b0;
      end
   endtask

   // Verdict from the schedule: the first deciding cycle ends the run.
   task automatic model(output int len, output bit ep, output bit et);
      bit f;
      bit decided;
      f = 1'b0; decided = 1'b0;
      len = TO; ep = 1'b0; et = 1'b1;
      for (int k = 1; k <= TO; k++) begin
         if (!decided) begin
            f = f | s_fail[k];
`ifdef TEST_MONITOR_FAIL_FAST_EN
            if (s_fail[k]) begin
               len = k; ep = 1'b0; et = 1'b0; decided = 1'b1;
            end
`endif
            if (!decided && s_fin[k]) begin
               len = k; ep = !f; et = 1'b0; decided = 1'b1;
            end
         end
      end
   endtask

   // Two cycles of reset, then release; counts sampled cycles with test_reset high.
   task automatic reset_and_hold(output int highs, output bit done_seen);
      @(negedge clock);
      reset = 1'b0; test_fail = 1'b0; test_finish = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      highs = 0; done_seen = 1'b0;
      for (int i = 0; i < RC + 10; i++) begin
         if (done) done_seen = 1'b1;
         if (!test_reset) break;
         highs++;
         test_fail   = 1'($urandom);
         test_finish = 1'($urandom);
         @(negedge clock);
      end
   endtask

   task automatic test_reset_state();
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({test_reset, done, pass, timeout} !== 4'b1000 || cycles !== '0) begin
         failures++;
         $display("FAIL reset_state: got tr=%0b done=%0b pass=%0b to=%0b cycles=%0d, want 1 0 0 0 0",
                  test_reset, done, pass, timeout, cycles);
      end
   endtask

   task automatic test_schedule(input string name);
      int highs, len, done_at;
      bit dseen, ep, et;
      logic [CW+2:0] snap;
      reset_and_hold(highs, dseen);
      checks++;
      if (highs !== RC) begin
         failures++;
         $display("FAIL %s hold_len: got %0d want %0d", name, highs, RC);
      end
      checks++;
      if (dseen) begin
         failures++;
         $display("FAIL %s done_in_hold: got done=1 want 0", name);
      end
      model(len, ep, et);
      done_at = 0;
      for (int k = 1; k <= TO + 2; k++) begin
         test_fail   = s_fail[k];
         test_finish = s_fin[k];
         @(negedge clock);
         if (done) begin
            done_at = k;
            break;
         end
      end
      checks++;
      if (done_at !== len) begin
         failures++;
         $display("FAIL %s done_cycle: got %0d want %0d (0 = never)", name, done_at, len);
      end
      checks++;
      if ({done, pass, timeout} !== {1'b1, ep, et}) begin
         failures++;
         $display("FAIL %s verdict: got done=%0b pass=%0b to=%0b want 1 %0b %0b",
                  name, done, pass, timeout, ep, et);
      end
      checks++;
      if (cycles !== CW'(len)) begin
         failures++;
         $display("FAIL %s cycles: got %0d want %0d", name, cycles, len);
      end
      snap = {test_reset, done, pass, timeout, cycles};
      for (int i = 0; i < 20; i++) begin
         test_fail   = 1'($urandom);
         test_finish = 1'($urandom);
         @(negedge clock);
         checks++;
         if ({test_reset, done, pass, timeout, cycles} !== snap) begin
            failures++;
            $display("FAIL %s sticky[%0d]: got %h want %h", name, i,
                     {test_reset, done, pass, timeout, cycles}, snap);
         end
      end
   endtask

   task automatic test_pass();
      clear_sched(); s_fin[5] = 1'b1;
      test_schedule("pass_at5");
   endtask

   task automatic test_fail_then_finish();
      clear_sched(); s_fail[2] = 1'b1; s_fin[6] = 1'b1;
      test_schedule("fail2_fin6");
   endtask

   task automatic test_timeout();
      clear_sched();
      test_schedule("timeout");
   endtask

   task automatic test_finish_at_budget();
      clear_sched(); s_fin[TO] = 1'b1;
      test_schedule("finish_at_budget");
   endtask

   task automatic test_fail_finish_same();
      clear_sched(); s_fail[3] = 1'b1; s_fin[3] = 1'b1;
      test_schedule("fail_fin_same");
   endtask

   task automatic test_reset_mid_run();
      int highs;
      bit dseen;
      clear_sched();
      reset_and_hold(highs, dseen);
      for (int k = 1; k <= 3; k++) begin
         test_fail = 1'b0; test_finish = 1'b0;
         @(negedge clock);
      end
      reset = 1'b0; test_fail = 1'b1; test_finish = 1'b1;
      @(negedge clock);
      checks++;
      if ({test_reset, done, pass, timeout} !== 4'b1000 || cycles !== '0) begin
         failures++;
         $display("FAIL mid_run_reset: got tr=%0b done=%0b pass=%0b to=%0b cycles=%0d, want 1 0 0 0 0",
                  test_reset, done, pass, timeout, cycles);
      end
      s_fin[4] = 1'b1;
      test_schedule("after_mid_reset");
   endtask

   task automatic test_reset_in_done();
      clear_sched(); s_fin[2] = 1'b1;
      test_schedule("pre_done_reset");
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({test_reset, done, pass, timeout} !== 4'b1000 || cycles !== '0) begin
         failures++;
         $display("FAIL done_reset: got tr=%0b done=%0b pass=%0b to=%0b cycles=%0d, want 1 0 0 0 0",
                  test_reset, done, pass, timeout, cycles);
      end
      clear_sched(); s_fail[1] = 1'b1; s_fin[7] = 1'b1;
      test_schedule("after_done_reset");
   endtask

   task automatic test_random();
      int fin_at;
      int fail_rate;
      for (int r = 0; r < 30; r++) begin
         clear_sched();
         fin_at    = $urandom_range(1, TO + 2);
         fail_rate = $urandom_range(0, 3);
         for (int k = 1; k <= SL; k++) begin
            s_fail[k] = (fail_rate != 0) && ($urandom_range(0, 4 * fail_rate) == 0);
            s_fin[k]  = (k >= fin_at) ? 1'($urandom) : 1'b0;
         end
         if (fin_at <= TO) s_fin[fin_at] = 1'b1;
         test_schedule($sformatf("random%0d", r));
      end
   endtask

   initial begin
      test_reset_state();
      test_pass();
      test_fail_then_finish();
      test_timeout();
      test_finish_at_budget();
      test_fail_finish_same();
      test_reset_mid_run();
      test_reset_in_done();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
